// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU.
// Returns {remainder, quotient} 34 edges after accept, or zero after 2 edges on divide-by-zero.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [64:0] work;
    logic [31:0] divisor;
    logic [5:0]  cnt;
    logic        q_neg;
    logic        r_neg;

    logic        accept;
    logic        neg1;
    logic        neg2;
    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    logic [32:0] trial;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Signed operands are reduced to magnitudes; the signs are reapplied at the end.
    assign accept       = start_i && !annul_i;
    assign neg1         = signed_div_i && opdata1_i[31];
    assign neg2         = signed_div_i && opdata2_i[31];
    assign dividend_abs = neg1 ? (~opdata1_i + 32'd1) : opdata1_i;
    assign divisor_abs  = neg2 ? (~opdata2_i + 32'd1) : opdata2_i;

    assign trial   = work[64:32] - {1'b0, divisor};
    assign quo_fix = q_neg ? (~work[31:0] + 32'd1) : work[31:0];
    assign rem_fix = r_neg ? (~work[64:33] + 32'd1) : work[64:33];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FREE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FREE: begin
                if (accept) begin
                    state_next = (opdata2_i == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                state_next = annul_i ? FREE : END;
            end
            ON: begin
                if (annul_i) begin
                    state_next = FREE;
                end else if (cnt == 6'd32) begin
                    state_next = END;
                end
            end
            END: begin
                if (!start_i) begin
                    state_next = FREE;
                end
            end
            default: state_next = FREE;
        endcase
    end

    // Datapath: one trial subtraction per edge in ON, result load on the 33rd edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work     <= 65'd0;
            divisor  <= 32'd0;
            cnt      <= 6'd0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    if (accept) begin
                        work    <= {32'd0, dividend_abs, 1'b0};
                        divisor <= divisor_abs;
                        q_neg   <= neg1 ^ neg2;
                        r_neg   <= neg1;
                        cnt     <= 6'd0;
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        cnt <= 6'd0;
                    end else begin
                        result_o <= 64'd0;
                        ready_o  <= 1'b1;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        cnt <= 6'd0;
                    end else if (cnt == 6'd32) begin
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= 1'b1;
                    end else begin
                        if (trial[32]) begin
                            work <= {work[63:0], 1'b0};
                        end else begin
                            work <= {trial[31:0], work[31:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                        cnt      <= 6'd0;
                    end
                end
                default: begin
                    cnt <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: vector table plus scoreboard queue,
// with hand-written annul and asynchronous-reset sequences.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Independent reference using the language's own division operators.
    function automatic logic [63:0] refModel(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sd;
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sd = b;
        q  = sa / sd;
        r  = sa % sd;
        return {r, q};
    endfunction

    // One full handshake: accept, scramble operands, wait, check, hold, release.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] exp, input int lat, input string name);
        int          edges;
        logic [63:0] want;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        edges     = 1;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        while (!ready_o && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        checkOutput({name, "_latency"}, 64'(edges), 64'(lat));
        want = sb.pop_front();
        checkOutput({name, "_result"}, result_o, want);
        @(negedge clk);
        checkOutput({name, "_hold_ready"}, 64'(ready_o), 64'd1);
        checkOutput({name, "_hold_result"}, result_o, want);
        start_i = 1'b0;
        @(negedge clk);
        checkOutput({name, "_release_ready"}, 64'(ready_o), 64'd0);
        checkOutput({name, "_release_result"}, result_o, 64'd0);
    endtask

    initial begin
        int          seen;
        int          edges;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF, 34};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 34};
        vecs[2] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 34};
        vecs[3] = '{1'b1, 32'd123,       32'd0,         64'd0,                   2};
        vecs[4] = '{1'b0, 32'd123,       32'd0,         64'd0,                   2};
        vecs[5] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 34};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000_0000_0000, 34};
        vecs[7] = '{1'b0, 32'd5,         32'd7,         64'h0000_0005_0000_0000, 34};
        vecs[8] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFF_FFFE_0000_000E, 34};
        vecs[9] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF, 34};

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #12;
        checkOutput("reset_ready", 64'(ready_o), 64'd0);
        checkOutput("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                          $sformatf("vec%0d", i));
        end

        $display("[TB] random pairs");
        for (int i = 0; i < 8; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 6) b = 32'd0;
            applyStimulus(sgn, a, b, refModel(sgn, a, b), (b == 32'd0) ? 2 : 34,
                          $sformatf("rand%0d", i));
        end

        $display("[TB] annul mid-division");
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'hFFFF_FFFF;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        seen    = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        checkOutput("annul_no_ready", 64'(seen), 64'd0);
        applyStimulus(1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 34, "after_annul");

        $display("[TB] async reset mid-division");
        @(negedge clk);
        signed_div_i = 1'b1;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (15) @(negedge clk);
        #2;
        rst     = 1'b1;
        start_i = 1'b0;
        #1;
        checkOutput("rst_on_ready", 64'(ready_o), 64'd0);
        checkOutput("rst_on_result", result_o, 64'd0);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        checkOutput("rst_on_discard", 64'(seen), 64'd0);

        $display("[TB] async reset while holding a result");
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        edges        = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (!ready_o && edges < 200);
        checkOutput("rst_end_latency", 64'(edges), 64'd34);
        checkOutput("rst_end_result", result_o, {32'd1, 32'd333});
        #2;
        rst     = 1'b1;
        start_i = 1'b0;
        #1;
        checkOutput("rst_end_ready_cleared", 64'(ready_o), 64'd0);
        checkOutput("rst_end_result_cleared", result_o, 64'd0);
        rst = 1'b0;

        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 34, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. Execute raises `start_i` with both operands and holds it until `ready_o`; the divider runs a 32-iteration restoring (trial-subtraction) algorithm and returns `{remainder, quotient}` as one 64-bit result destined for HI/LO. Execute stalls the pipeline while the divider is busy, and aborts an in-flight division via `annul_i` on a flush.

## Interface
- No parameters; datapath fixed at 32-bit operands, 64-bit result.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset (asserted = `RstEnable`).
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i`  in  32  dividend; sampled only on accept.
- `opdata2_i`  in  32  divisor; sampled only on accept.
- `start_i`  in  1  request; held high by execute until it consumes the result.
- `annul_i`  in  1  cancel current/pending division.
- `result_o`  out  64  `[63:32]` remainder (HI), `[31:0]` quotient (LO); registered.
- `ready_o`  out  1  result valid; registered.

## Operation
- States: FREE, BYZERO, ON, END. Reset → FREE, `ready_o`=0, `result_o`=0, iteration counter=0.
- FREE: on edge with `start_i`=1 and `annul_i`=0, accept: divisor==0 → BYZERO; else → ON. Operands latched at accept; later operand changes ignored.
- Signed accept: dividend and divisor replaced by absolute values when negative; record `q_neg` = sign1 XOR sign2, `r_neg` = sign1. Unsigned: used as-is, no fix-up.
- ON: 65-bit working register initialised `{32'b0, |dividend|, 1'b0}`. Each edge: trial = upper 33 bits − {1'b0, |divisor|}; if trial negative, shift left inserting 0; else replace upper bits with trial and shift inserting 1. Counter increments each iteration.
- After iteration 32: quotient = low 32 bits, remainder = bits [64:33]. Apply signed fix-up (two's-complement negate quotient if `q_neg`, remainder if `r_neg`). Load `result_o`, set `ready_o`=1, → END.
- BYZERO: next edge loads `result_o`=0, `ready_o`=1, → END. No trap; architectural result undefined, fixed here as zero.
- END: hold `result_o`/`ready_o` while `start_i`=1. Edge with `start_i`=0 → FREE, `ready_o`=0, `result_o`=0, counter cleared.
- `annul_i`=1 in ON or BYZERO: next edge → FREE, counter cleared, `ready_o` stays 0, no result produced. `annul_i` in FREE blocks acceptance. In END, `annul_i` has no effect (release still via `start_i`=0).
- Overflow case 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0. No exception.

## Timing
- Accept at edge E. Iterations at edges E+1 … E+32. Fix-up/result load at E+33; `ready_o` high from E+33 onward. Total: 34 edges from accept to valid.
- Divide-by-zero: BYZERO after E, `ready_o` high after E+1.
- Back-to-back: `start_i` must drop for ≥1 edge in END before a new accept; earliest next accept is the edge after the return to FREE.
- `rst` asserted any time (mid-ON included): immediate return to FREE, outputs 0, partial work discarded, independent of `clk`.
- `start_i` dropped during ON without `annul_i`: division completes, enters END, returns to FREE on the next edge. Execute never does this.

## Test plan
- Unsigned: 0xFFFFFFFF / 0x00000010 → after 34 edges `ready_o`=1, `result_o`=0x0000000F_0FFFFFFF; held until `start_i` falls, then both outputs 0 one edge later.
- Signed: −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: 123 / 0 (signed and unsigned) → `ready_o`=1 two edges after accept, `result_o`=0.
- Signed overflow 0x80000000 / 0xFFFFFFFF → `result_o`=0x00000000_80000000, 34-edge latency.
- Annul at iteration 10 → FREE, `ready_o` never rises; a new 100 / 7 accepted afterwards yields 0x00000002_0000000E.
- Async `rst` pulse mid-ON (between edges) → outputs 0 immediately. Operand change after accept → result unaffected. Randomised signed/unsigned pairs checked against a reference model.
